grid_tile_mapper: RTL and testbench

Parametrised tile-state store and pixel-to-tile lookup pipeline for the game-board display path. Holds per-square state for `NUM_BOARDS` square grids of size `GRID_DIM`×`GRID_DIM`, maps each VGA scan coordinate to board, square and in-square offset, and presents the square's stored data with a fixed 2-cycle latency. Downstream sprite and colour muxing consume its outputs. Compared with the previous fixed 2×10×10 board logic, it adds:

- parametrised geometry;
- a self-clearing store that maps to block RAM;
- update validation;
- frame-rate blinking of the selection highlight.

---
 rtl/grid_tile_mapper_if.sv | 37 +++
 rtl/grid_tile_mapper.sv | 207 ++++++++++++++++++++
 tb/tb_grid_tile_mapper.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/grid_tile_mapper_if.sv
// Update request/response and pixel lookup result bundle for grid_tile_mapper.
// Latency: wires only; pix_* carry the 2-cycle lookup result, upd_err lags its request by 1 cycle.
// Backpressure: upd_ready gates update acceptance; the pixel side never stalls.
interface grid_tile_mapper_if #(
   parameter int B_W     = 1,
   parameter int S_W     = 7,
   parameter int DATA_W  = 9,
   parameter int SQ_LOG2 = 4
);
   logic              upd_valid;
   logic [B_W-1:0]    upd_board;
   logic [S_W-1:0]    upd_square;
   logic [DATA_W-1:0] upd_data;
   logic              upd_ready;
   logic              upd_err;

   logic               pix_valid;
   logic [B_W-1:0]     pix_board;
   logic [S_W-1:0]     pix_square;
   logic [DATA_W-1:0]  pix_data;
   logic [SQ_LOG2-1:0] off_x;
   logic [SQ_LOG2-1:0] off_y;
   logic               on_grid_line;
   logic               sel_active;

   modport master (
      output upd_valid, upd_board, upd_square, upd_data,
      input  upd_ready, upd_err,
      input  pix_valid, pix_board, pix_square, pix_data, off_x, off_y, on_grid_line, sel_active
   );

   modport slave (
      input  upd_valid, upd_board, upd_square, upd_data,
      output upd_ready, upd_err,
      output pix_valid, pix_board, pix_square, pix_data, off_x, off_y, on_grid_line, sel_active
   );
endinterface

// File: rtl/grid_tile_mapper.sv
// Per-square tile state store with a self-clearing sweep and a pixel-to-square lookup pipeline.
// Latency: scan coordinate to pix_* is 2 cycles, one pixel per cycle; updates land in 1 cycle.
// Backpressure: upd_ready low during the post-reset clear sweep; the pixel path never stalls.
module grid_tile_mapper #(
   parameter int NUM_BOARDS    = 2,
   parameter int GRID_DIM      = 10,
   parameter int SQ_LOG2       = 4,
   parameter int COL0          = 263,
   parameter int ROW0          = 62,
   parameter int BOARD_PITCH_Y = 195,
   parameter int DATA_W        = 9,
   parameter int BLINK_FRAMES  = 16
) (
   input  logic       vga_clk,
   input  logic       rst,
   input  logic [9:0] next_x,
   input  logic [9:0] next_y,
   input  logic       frame_tick,
   grid_tile_mapper_if.slave bus
);
   localparam int GRID_SQ  = GRID_DIM * GRID_DIM;
   localparam int B_W      = (NUM_BOARDS > 1) ? $clog2(NUM_BOARDS) : 1;
   localparam int S_W      = (GRID_SQ > 1) ? $clog2(GRID_SQ) : 1;
   localparam int DEPTH    = NUM_BOARDS * GRID_SQ;
   localparam int A_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int GRID_PIX = GRID_DIM << SQ_LOG2;
   localparam int BF_M1    = (BLINK_FRAMES > 0) ? BLINK_FRAMES - 1 : 0;
   localparam int FC_W     = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   typedef enum logic {ST_CLEAR, ST_IDLE} state_t;

   state_t            state, state_nxt;
   logic [A_W-1:0]    clr_cnt, clr_cnt_nxt;
   logic              upd_ok;
   logic              wr_en;
   logic [A_W-1:0]    wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              err_nxt;
   logic              err_q;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [DATA_W-1:0] rd_q;

   // stage-1 combinational decode
   int                 dx, rel, dy;
   int                 hit_b;
   logic               hit;

   logic               s1_vld;
   logic [B_W-1:0]     s1_board;
   logic [S_W-1:0]     s1_square;
   logic [SQ_LOG2-1:0] s1_offx, s1_offy;
   logic [A_W-1:0]     s1_addr;

   logic               s2_vld, s2_keep;
   logic [B_W-1:0]     s2_board;
   logic [S_W-1:0]     s2_square;
   logic [SQ_LOG2-1:0] s2_offx, s2_offy;
   logic [DATA_W-1:0]  pix_data_w;
   logic               grid_line_w;

   logic [FC_W-1:0]    frame_cnt;
   logic               blink_phase;

   assign upd_ok = (int'(bus.upd_board) < NUM_BOARDS) && (int'(bus.upd_square) < GRID_SQ);

   // Control state and clear-sweep address register.
   always_ff @(posedge vga_clk) begin
      if (rst) begin
         state   <= ST_CLEAR;
         clr_cnt <= '0;
         err_q   <= 1'b0;
      end else begin
         state   <= state_nxt;
         clr_cnt <= clr_cnt_nxt;
         err_q   <= err_nxt;
      end
   end

   // Next state and write-port selection: clear sweep owns the port until it finishes.
   always_comb begin
      state_nxt   = state;
      clr_cnt_nxt = clr_cnt;
      wr_en       = 1'b0;
      wr_addr     = '0;
      wr_data     = '0;
      err_nxt     = 1'b0;
      case (state)
         ST_CLEAR: begin
            wr_en   = 1'b1;
            wr_addr = clr_cnt;
            if (clr_cnt == A_W'(DEPTH - 1)) state_nxt = ST_IDLE;
            else clr_cnt_nxt = clr_cnt + A_W'(1);
         end
         ST_IDLE: begin
            if (bus.upd_valid) begin
               if (upd_ok) begin
                  wr_en   = 1'b1;
                  wr_addr = A_W'(int'(bus.upd_board) * GRID_SQ + int'(bus.upd_square));
                  wr_data = bus.upd_data;
               end else begin
                  err_nxt = 1'b1;
               end
            end
         end
         default: state_nxt = ST_CLEAR;
      endcase
   end

   // Single write port into the square store.
   always_ff @(posedge vga_clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   // Registered read port; a same-cycle write to this address is not seen until the next read.
   always_ff @(posedge vga_clk) begin
      rd_q <= mem[s1_addr];
   end

   // Map the scan coordinate to a board; iterate downwards so the lowest board index wins.
   always_comb begin
      dx    = int'(next_x) - COL0;
      dy    = 0;
      rel   = 0;
      hit   = 1'b0;
      hit_b = 0;
      if (dx >= 0 && dx < GRID_PIX) begin
         for (int b = NUM_BOARDS - 1; b >= 0; b--) begin
            rel = int'(next_y) - (ROW0 + b * BOARD_PITCH_Y);
            if (rel >= 0 && rel < GRID_PIX) begin
               hit   = 1'b1;
               hit_b = b;
               dy    = rel;
            end
         end
      end
   end

   // Stage 1: register the decoded square and issue the store read address.
   always_ff @(posedge vga_clk) begin
      if (rst || !hit) begin
         s1_vld    <= 1'b0;
         s1_board  <= '0;
         s1_square <= '0;
         s1_offx   <= '0;
         s1_offy   <= '0;
         s1_addr   <= '0;
      end else begin
         s1_vld    <= 1'b1;
         s1_board  <= B_W'(hit_b);
         s1_square <= S_W'((dy >> SQ_LOG2) * GRID_DIM + (dx >> SQ_LOG2));
         s1_offx   <= SQ_LOG2'(dx);
         s1_offy   <= SQ_LOG2'(dy);
         s1_addr   <= A_W'(hit_b * GRID_SQ + (dy >> SQ_LOG2) * GRID_DIM + (dx >> SQ_LOG2));
      end
   end

   // Stage 2: forward the geometry alongside the read result; store data only counts once cleared.
   always_ff @(posedge vga_clk) begin
      if (rst) begin
         s2_vld    <= 1'b0;
         s2_keep   <= 1'b0;
         s2_board  <= '0;
         s2_square <= '0;
         s2_offx   <= '0;
         s2_offy   <= '0;
      end else begin
         s2_vld    <= s1_vld;
         s2_keep   <= s1_vld && (state == ST_IDLE);
         s2_board  <= s1_board;
         s2_square <= s1_square;
         s2_offx   <= s1_offx;
         s2_offy   <= s1_offy;
      end
   end

   // Frame counter and highlight phase; a zero period pins the phase on.
   always_ff @(posedge vga_clk) begin
      if (rst) begin
         frame_cnt   <= '0;
         blink_phase <= 1'b1;
      end else if (BLINK_FRAMES == 0) begin
         blink_phase <= 1'b1;
      end else if (frame_tick) begin
         if (frame_cnt == FC_W'(BF_M1)) begin
            frame_cnt   <= '0;
            blink_phase <= ~blink_phase;
         end else begin
            frame_cnt <= frame_cnt + FC_W'(1);
         end
      end
   end

   assign pix_data_w  = s2_keep ? rd_q : '0;
   assign grid_line_w = s2_vld && ((s2_offx == '0) || (s2_offy == '0));

   assign bus.upd_ready    = (state == ST_IDLE);
   assign bus.upd_err      = err_q;
   assign bus.pix_valid    = s2_vld;
   assign bus.pix_board    = s2_board;
   assign bus.pix_square   = s2_square;
   assign bus.pix_data     = pix_data_w;
   assign bus.off_x        = s2_offx;
   assign bus.off_y        = s2_offy;
   assign bus.on_grid_line = grid_line_w;
   assign bus.sel_active   = s2_vld & pix_data_w[0] & blink_phase & ~grid_line_w;
endmodule

// File: tb/tb_grid_tile_mapper.sv
// Bench for grid_tile_mapper: constant vectors, hand sequences and a randomized stream.
// Latency: expects pix_* 2 cycles after each coordinate and upd_err 1 cycle after a request.
// Backpressure: only issues updates once upd_ready is expected high (except the in-clear probe).
module tb_grid_tile_mapper;
   localparam int NB = 2, GD = 10, SQL = 4, C0 = 263, R0 = 62, PITCH = 195, DW = 9, BF = 16;
   localparam int GSQ = GD * GD, DEPTH = NB * GSQ, GPIX = GD * (1 << SQL);

   logic       vga_clk = 1'b0;
   logic       rst = 1'b1;
   logic [9:0] next_x = '0, next_y = '0;
   logic       frame_tick = 1'b0;

   grid_tile_mapper_if #(.B_W(1), .S_W(7), .DATA_W(DW), .SQ_LOG2(SQL)) bus ();

   grid_tile_mapper #(
      .NUM_BOARDS(NB), .GRID_DIM(GD), .SQ_LOG2(SQL), .COL0(C0), .ROW0(R0),
      .BOARD_PITCH_Y(PITCH), .DATA_W(DW), .BLINK_FRAMES(BF)
   ) dut (
      .vga_clk(vga_clk), .rst(rst), .next_x(next_x), .next_y(next_y),
      .frame_tick(frame_tick), .bus(bus)
   );

   always #5 vga_clk = ~vga_clk;

   int checks = 0;
   int errors = 0;
   int ref_mem [DEPTH];
   int tick_cnt = 0;

   typedef struct {
      int valid, board, square, offx, offy, data, gl;
   } pix_t;

   typedef struct {
      int x, y, v, b, s, ox, oy, g;
   } vec_t;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
      end
   endtask

   function automatic logic [43:0] pk(int v, int b, int s, int ox, int oy, int d, int g, int se);
      return {4'(v), 4'(b), 8'(s), 4'(ox), 4'(oy), 12'(d), 4'(g), 4'(se)};
   endfunction

   function automatic int phase_now();
      return ((tick_cnt / BF) % 2 == 0) ? 1 : 0;
   endfunction

   function automatic logic [43:0] got_vec();
      return pk(int'(bus.pix_valid), int'(bus.pix_board), int'(bus.pix_square), int'(bus.off_x),
                int'(bus.off_y), int'(bus.pix_data), int'(bus.on_grid_line), int'(bus.sel_active));
   endfunction

   function automatic logic [43:0] exp_vec(pix_t p);
      int se;
      se = (p.valid == 1 && p.data % 2 == 1 && phase_now() == 1 && p.gl == 0) ? 1 : 0;
      return pk(p.valid, p.board, p.square, p.offx, p.offy, p.data, p.gl, se);
   endfunction

   // Reference: find the first board whose rectangle holds (x,y), then divide into squares.
   function automatic pix_t model_pix(int x, int y);
      pix_t p;
      int rx, ry;
      p = '{default: 0};
      rx = x - C0;
      if (rx >= 0 && rx < GPIX) begin
         for (int b = 0; b < NB; b++) begin
            ry = y - (R0 + b * PITCH);
            if (p.valid == 0 && ry >= 0 && ry < GPIX) begin
               p.valid  = 1;
               p.board  = b;
               p.square = (ry / 16) * GD + rx / 16;
               p.offx   = rx % 16;
               p.offy   = ry % 16;
            end
         end
      end
      if (p.valid == 1) begin
         p.data = ref_mem[p.board * GSQ + p.square];
         p.gl   = (p.offx == 0 || p.offy == 0) ? 1 : 0;
      end
      return p;
   endfunction

   task automatic do_reset(input int hold);
      @(posedge vga_clk); #1;
      rst = 1'b1;
      bus.upd_valid = 1'b0;
      frame_tick = 1'b0;
      repeat (hold) @(posedge vga_clk);
      @(negedge vga_clk);
      check("rst_outs", {bus.upd_ready, bus.upd_err, got_vec()}, 64'd0);
      @(posedge vga_clk); #1;
      rst = 1'b0;
      tick_cnt = 0;
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = 0;
   endtask

   // Starts in clear cycle 0; ends at the negedge of cycle DEPTH.
   task automatic run_clear(input bit probe);
      for (int k = 0; k <= DEPTH; k++) begin
         if (k > 0) begin
            @(posedge vga_clk); #1;
         end
         bus.upd_valid  = (probe && k == 10);
         bus.upd_board  = 1'b0;
         bus.upd_square = 7'd5;
         bus.upd_data   = 9'h1FF;
         @(negedge vga_clk);
         check("clr_ready", {63'd0, bus.upd_ready}, (k >= DEPTH) ? 64'd1 : 64'd0);
         if (probe && k == 11) check("clr_no_err", {63'd0, bus.upd_err}, 64'd0);
      end
   endtask

   task automatic do_write(input int b, input int sq, input int d, output logic err1);
      @(posedge vga_clk); #1;
      bus.upd_valid  = 1'b1;
      bus.upd_board  = 1'(b);
      bus.upd_square = 7'(sq);
      bus.upd_data   = 9'(d);
      if (b < NB && sq < GSQ) ref_mem[b * GSQ + sq] = d;
      @(posedge vga_clk); #1;
      bus.upd_valid = 1'b0;
      @(negedge vga_clk);
      err1 = bus.upd_err;
   endtask

   task automatic look(input string name, input int x, input int y);
      pix_t p;
      @(posedge vga_clk); #1;
      next_x = 10'(x);
      next_y = 10'(y);
      p = model_pix(x, y);
      @(posedge vga_clk);
      @(posedge vga_clk);
      @(negedge vga_clk);
      check(name, {20'd0, got_vec()}, {20'd0, exp_vec(p)});
   endtask

   task automatic pulse_ticks(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge vga_clk); #1;
         frame_tick = 1'b1;
         @(posedge vga_clk); #1;
         frame_tick = 1'b0;
         tick_cnt++;
      end
   endtask

   vec_t tbl [12];
   pix_t pq [$];
   int   eq [$];

   initial begin
      logic e;
      pix_t p;
      int x, y, uv, ub, us, ud, tk, ee;

      bus.upd_valid  = 1'b0;
      bus.upd_board  = '0;
      bus.upd_square = '0;
      bus.upd_data   = '0;

      //            x    y    v  b  sq  ox  oy  gl
      tbl[0]  = '{262, 100, 0, 0,  0,  0,  0, 0};
      tbl[1]  = '{422, 100, 1, 0, 29, 15,  6, 0};
      tbl[2]  = '{423, 100, 0, 0,  0,  0,  0, 0};
      tbl[3]  = '{300, 221, 1, 0, 92,  5, 15, 0};
      tbl[4]  = '{300, 222, 0, 0,  0,  0,  0, 0};
      tbl[5]  = '{300, 240, 0, 0,  0,  0,  0, 0};
      tbl[6]  = '{300, 256, 0, 0,  0,  0,  0, 0};
      tbl[7]  = '{300, 257, 1, 1,  2,  5,  0, 1};
      tbl[8]  = '{263,  62, 1, 0,  0,  0,  0, 1};
      tbl[9]  = '{422, 416, 1, 1, 99, 15, 15, 0};
      tbl[10] = '{422, 417, 0, 0,  0,  0,  0, 0};
      tbl[11] = '{270,  61, 0, 0,  0,  0,  0, 0};

      // Reset, clear sweep with an ignored in-clear update to board 0 square 5.
      do_reset(3);
      run_clear(1'b1);
      look("cleared_sq5", 343, 62);
      check("cleared_sq5_data", {55'd0, bus.pix_data}, 64'd0);

      // Lookup of a freshly written square.
      do_write(1, 37, 'h1A5, e);
      check("lookup_wr_err", {63'd0, e}, 64'd0);
      look("lookup_model", 380, 307);
      check("lookup_const", {20'd0, got_vec()}, {20'd0, pk(1, 1, 37, 5, 2, 'h1A5, 0, 1)});

      // Geometry edges from constant vectors.
      foreach (tbl[i]) begin
         @(posedge vga_clk); #1;
         next_x = 10'(tbl[i].x);
         next_y = 10'(tbl[i].y);
         @(posedge vga_clk);
         @(posedge vga_clk);
         @(negedge vga_clk);
         check($sformatf("edge_%0d_%0d", tbl[i].x, tbl[i].y), {20'd0, got_vec()},
               {20'd0, pk(tbl[i].v, tbl[i].b, tbl[i].s, tbl[i].ox, tbl[i].oy, 0, tbl[i].g, 0)});
      end

      // Rejected updates: square 100 would alias board 1 square 0 if it leaked through.
      do_write(0, 100, 'h0AA, e);
      check("bad_sq100_err", {63'd0, e}, 64'd1);
      @(negedge vga_clk);
      check("bad_err_one_cycle", {63'd0, bus.upd_err}, 64'd0);
      do_write(1, 127, 'h155, e);
      check("bad_sq127_err", {63'd0, e}, 64'd1);
      check("idle_ready", {63'd0, bus.upd_ready}, 64'd1);
      look("bad_no_alias", 263, 257);
      check("bad_no_alias_data", {55'd0, bus.pix_data}, 64'd0);

      // Read/write collision on board 0 square 5.
      do_write(0, 5, 'h055, e);
      @(posedge vga_clk); #1;
      next_x = 10'd343;
      next_y = 10'd62;
      @(posedge vga_clk); #1;
      bus.upd_valid  = 1'b1;
      bus.upd_board  = 1'b0;
      bus.upd_square = 7'd5;
      bus.upd_data   = 9'h0F0;
      @(posedge vga_clk); #1;
      bus.upd_valid = 1'b0;
      ref_mem[5] = 'h0F0;
      @(negedge vga_clk);
      check("collide_old", {55'd0, bus.pix_data}, 64'h055);
      @(negedge vga_clk);
      check("collide_new", {55'd0, bus.pix_data}, 64'h0F0);

      // Blink of the selection highlight on board 0 square 11.
      do_write(0, 11, 'h001, e);
      look("blink_on", 282, 81);
      check("blink_on_sel", {63'd0, bus.sel_active}, 64'd1);
      look("blink_line", 279, 81);
      check("blink_line_sel", {63'd0, bus.sel_active}, 64'd0);
      pulse_ticks(15);
      look("blink_15", 282, 81);
      check("blink_15_sel", {63'd0, bus.sel_active}, 64'd1);
      pulse_ticks(1);
      look("blink_16", 282, 81);
      check("blink_16_sel", {63'd0, bus.sel_active}, 64'd0);
      look("blink_16_line", 279, 81);
      check("blink_16_line_sel", {63'd0, bus.sel_active}, 64'd0);
      pulse_ticks(16);
      look("blink_32", 282, 81);
      check("blink_32_sel", {63'd0, bus.sel_active}, 64'd1);

      // Randomized stream: coordinates, updates and frame ticks every cycle.
      for (int c = 0; c < 3000; c++) begin
         @(posedge vga_clk); #1;
         x  = int'($urandom_range(255, 430));
         y  = int'($urandom_range(50, 425));
         uv = ($urandom_range(0, 9) < 3) ? 1 : 0;
         ub = int'($urandom_range(0, 1));
         us = int'($urandom_range(0, 127));
         ud = int'($urandom_range(0, 511));
         tk = ($urandom_range(0, 7) == 0) ? 1 : 0;
         next_x = 10'(x);
         next_y = 10'(y);
         bus.upd_valid  = 1'(uv);
         bus.upd_board  = 1'(ub);
         bus.upd_square = 7'(us);
         bus.upd_data   = 9'(ud);
         frame_tick     = 1'(tk);
         ee = 0;
         if (uv == 1) begin
            if (us < GSQ) ref_mem[ub * GSQ + us] = ud;
            else ee = 1;
         end
         pq.push_back(model_pix(x, y));
         eq.push_back(ee);
         @(negedge vga_clk);
         if (c >= 2) begin
            p = pq.pop_front();
            check("rand_pix", {20'd0, got_vec()}, {20'd0, exp_vec(p)});
         end
         if (c >= 1) check("rand_err", {63'd0, bus.upd_err}, 64'(eq.pop_front()));
         if (tk == 1) tick_cnt++;
      end
      @(posedge vga_clk); #1;
      bus.upd_valid = 1'b0;
      frame_tick = 1'b0;

      // Reset in the middle of a clear restarts the sweep from address 0.
      do_reset(2);
      repeat (50) @(posedge vga_clk);
      do_reset(2);
      run_clear(1'b0);
      look("post_clear", 380, 307);
      check("post_clear_data", {55'd0, bus.pix_data}, 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
